operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Read side of the CPU register path: takes a two-source operand request, reads both
//  sources from the register bank over a 1-cycle-latency read port, and presents them to
//  the ALU as a stable op_a/op_b pair under a valid/ready handshake. Sits between the
//  decoder (request side) and the ALU inputs, opposite the ALU-result save path.
// PARAMETERS
//  DATA_W   8   operand / register width (bits)
//  ADDR_W   2   register-index width (2**ADDR_W registers)
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  reset      in   1       synchronous, active-low (0 = reset), sampled on posedge clk
//  req_valid  in   1       decoder request valid
//  req_ready  out  1       unit can accept a request (registered)
//  src_a      in   ADDR_W  register index of operand A (sampled on accept)
//  src_b      in   ADDR_W  register index of operand B (sampled on accept)
//  rd_en      out  1       register-bank read strobe
//  rd_addr    out  ADDR_W  register-bank read index
//  rd_data    in   DATA_W  read data, valid 1 cycle after rd_en
//  save       in   1       ALU result write strobe (bypass only)
//  wr_addr    in   ADDR_W  ALU result destination index (bypass only)
//  alu_out    in   DATA_W  ALU result being written (bypass only)
//  op_a       out  DATA_W  operand A to ALU
//  op_b       out  DATA_W  operand B to ALU
//  op_valid   out  1       op_a/op_b valid
//  op_ready   in   1       ALU accepts operands
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; req_ready=1; rd_en=0; rd_addr=0;
//    op_a=op_b=0; op_valid=0. Overrides any in-flight fetch; no partial result survives.
//  - FSM IDLE -> RD_A -> RD_B -> WAIT_B -> HOLD -> IDLE. All outputs registered.
//  - IDLE: req_ready=1. Accept = req_valid & req_ready at cycle T: latch src_a/src_b,
//    req_ready->0, go RD_A.
//  - RD_A (T+1): rd_en=1, rd_addr=src_a.  RD_B (T+2): rd_en=1, rd_addr=src_b; op_a<=rd_data.
//  - WAIT_B (T+3): rd_en=0; op_b<=rd_data; op_valid<=1; go HOLD.
//  - HOLD (op_valid=1 from T+4): op_a/op_b/op_valid held stable while op_ready=0 (any stall
//    length). On op_valid & op_ready: op_valid<=0, req_ready<=1, go IDLE.
//  - Latency accept -> op_valid = 4 cycles; min request spacing = 5 cycles (no overlap).
//  - src_a==src_b: still two reads; op_a==op_b. req_valid outside IDLE is ignored (no queue).
//  - rd_data is don't-care outside the capture cycles (RD_B, WAIT_B).
//  - op_a/op_b keep last values after handshake until overwritten by next fetch.
// CONFIGURATION
//  OPERAND_BYPASS_EN defined: in each capture cycle, if save==1 and wr_addr equals the
//    index whose data is returning, capture alu_out instead of rd_data (result forwarding).
//  Undefined: save/wr_addr/alu_out ports present but ignored; capture always uses rd_data.
// STRUCTURE
//  - Shared package: FSM state encoding (OF_IDLE, OF_RD_A, OF_RD_B, OF_WAIT_B, OF_HOLD),
//    default DATA_W/ADDR_W constants.
//  - Single optional sub-module: operand_bypass_mux (compare + 2:1 select), instantiated
//    only under OPERAND_BYPASS_EN; otherwise flat.
// TESTING
//  1 reset=0 for 2 cycles mid-fetch (in RD_B) -> next cycle op_valid=0, op_a=op_b=0,
//    req_ready=1, rd_en=0.
//  2 bank R1=8'h3C, R2=8'hA5; request a=1,b=2 at T, op_ready=1 -> rd_addr 1 @T+1, 2 @T+2;
//    op_a=8'h3C, op_b=8'hA5, op_valid=1 @T+4 for exactly 1 cycle.
//  3 same request, op_ready=0 for 6 cycles -> operands and op_valid stable throughout;
//    req_valid pulses during stall ignored; IDLE one cycle after op_ready=1.
//  4 a=b=3, R3=8'hFF -> two reads of index 3; op_a=op_b=8'hFF.
//  5 OPERAND_BYPASS_EN: R2=8'h10, save=1 wr_addr=2 alu_out=8'h77 in WAIT_B for b=2 ->
//    op_b=8'h77; without the macro op_b=8'h10.
//  6 back-to-back requests with op_ready=1 -> second accept 5 cycles after first.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// ---------------------------------------------------------------------------
// operand_fetch_pkg : shared FSM encoding and default widths for operand_fetch
// ---------------------------------------------------------------------------
`default_nettype none

package operand_fetch_pkg;

  localparam int OF_DATA_W = 8;
  localparam int OF_ADDR_W = 2;

  typedef enum logic [2:0] {
    OF_IDLE   = 3'd0,
    OF_RD_A   = 3'd1,
    OF_RD_B   = 3'd2,
    OF_WAIT_B = 3'd3,
    OF_HOLD   = 3'd4
  } of_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_bypass_mux.sv
// ---------------------------------------------------------------------------
// operand_bypass_mux : forwards the ALU result when it targets the index being read
// ---------------------------------------------------------------------------
`default_nettype none

module operand_bypass_mux
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = OF_DATA_W,
  parameter int ADDR_W = OF_ADDR_W
) (
  input  logic              save,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] capture_data
);

  assign capture_data = (save && (wr_addr == rd_idx)) ? alu_out : rd_data;

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch : two-read operand fetch with valid/ready ALU handoff
// Optional result forwarding under OPERAND_BYPASS_EN
// ---------------------------------------------------------------------------
`default_nettype none

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = OF_DATA_W,
  parameter int ADDR_W = OF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              save,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready
);

  of_state_t         state, state_nxt;
  logic [ADDR_W-1:0] src_a_q, src_b_q, src_a_nxt, src_b_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt, capture_idx;
  logic              req_ready_nxt, rd_en_nxt, op_valid_nxt;
  logic [DATA_W-1:0] op_a_nxt, op_b_nxt, capture_data;

  // RD_B returns operand A's data, WAIT_B returns operand B's
  assign capture_idx = (state == OF_RD_B) ? src_a_q : src_b_q;

`ifdef OPERAND_BYPASS_EN
  operand_bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass (
    .save         (save),
    .wr_addr      (wr_addr),
    .rd_idx       (capture_idx),
    .alu_out      (alu_out),
    .rd_data      (rd_data),
    .capture_data (capture_data)
  );
`else
  logic unused_bypass;
  assign capture_data  = rd_data;
  assign unused_bypass = ^{save, wr_addr, alu_out, capture_idx};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= OF_IDLE;
      src_a_q   <= '0;
      src_b_q   <= '0;
      req_ready <= 1'b1;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      src_a_q   <= src_a_nxt;
      src_b_q   <= src_b_nxt;
      req_ready <= req_ready_nxt;
      rd_en     <= rd_en_nxt;
      rd_addr   <= rd_addr_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      op_valid  <= op_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    src_a_nxt     = src_a_q;
    src_b_nxt     = src_b_q;
    req_ready_nxt = req_ready;
    rd_en_nxt     = rd_en;
    rd_addr_nxt   = rd_addr;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    op_valid_nxt  = op_valid;
    unique case (state)
      OF_IDLE: begin
        if (req_valid && req_ready) begin
          src_a_nxt     = src_a;
          src_b_nxt     = src_b;
          req_ready_nxt = 1'b0;
          rd_en_nxt     = 1'b1;
          rd_addr_nxt   = src_a;
          state_nxt     = OF_RD_A;
        end
      end
      OF_RD_A: begin
        rd_addr_nxt = src_b_q;
        state_nxt   = OF_RD_B;
      end
      OF_RD_B: begin
        rd_en_nxt = 1'b0;
        op_a_nxt  = capture_data;
        state_nxt = OF_WAIT_B;
      end
      OF_WAIT_B: begin
        op_b_nxt     = capture_data;
        op_valid_nxt = 1'b1;
        state_nxt    = OF_HOLD;
      end
      OF_HOLD: begin
        if (op_ready) begin
          op_valid_nxt  = 1'b0;
          req_ready_nxt = 1'b1;
          state_nxt     = OF_IDLE;
        end
      end
      default: begin
        state_nxt     = OF_IDLE;
        req_ready_nxt = 1'b1;
        rd_en_nxt     = 1'b0;
        op_valid_nxt  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
